fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 14, meaning the highest valid instruction-memory address.
REQ-002 SHALL have parameter END_WORD, default 32'h00000000, meaning the end-of-program marker word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin fetching from address 0; honoured only in IDLE or DONE.
REQ-006 redirect_valid  input  1  branch or jump request; honoured only in FETCH.
REQ-007 redirect_addr  input  4  new fetch address.
REQ-008 imem_read_en  output  1  drives the instruction memory read_en.
REQ-009 imem_address  output  4  drives the instruction memory address.
REQ-010 imem_instruction  input  32  combinational memory data (valid in the same cycle as the address).
REQ-011 instr_valid  output  1  output slot holds an instruction.
REQ-012 instr_out  output  32  captured instruction.
REQ-013 instr_pc  output  4  address instr_out was fetched from.
REQ-014 instr_ready  input  1  consumer accepts the slot when instr_valid=1 and instr_ready=1.
REQ-015 busy  output  1  high in FETCH.
REQ-016 done  output  1  high in DONE when instr_valid=0.
REQ-017 addr_err  output  1  sticky flag: a redirect targeted an address greater than LAST_ADDR.

Function
REQ-018 SHALL implement the states IDLE, FETCH and DONE.
REQ-019 In IDLE, imem_read_en=0 and imem_address=0; start moves the block to FETCH with pc=0.
REQ-020 In FETCH, imem_address SHALL equal pc.
REQ-021 In FETCH, a "can capture" condition holds when instr_valid=0 or instr_ready=1; imem_read_en=1 only in a cycle where the block can capture.
REQ-022 Capture of a word other than END_WORD: next cycle instr_out=word, instr_pc=pc, instr_valid=1; pc increments by 1; one cycle from address to slot.
REQ-023 Capture of END_WORD: the word SHALL NOT be presented, the slot is cleared if it was being accepted, and the state goes to DONE.
REQ-024 Capture at pc=LAST_ADDR: the word is presented per REQ-022, then the state goes to DONE; pc never wraps past LAST_ADDR.
REQ-025 Stall: if the block cannot capture, pc, instr_out and instr_pc SHALL hold and the memory is not read.
REQ-026 redirect_valid in FETCH SHALL take priority over capture: instr_valid is cleared (flush) and pc takes redirect_addr in the next cycle.
REQ-027 Redirect with redirect_addr greater than LAST_ADDR: addr_err is set, the slot is flushed, and the state goes to DONE.
REQ-028 start in FETCH SHALL be ignored; redirect_valid in IDLE or DONE SHALL be ignored.
REQ-029 In DONE, imem_read_en=0 and any pending slot stays until accepted.
REQ-030 start in DONE SHALL clear addr_err, set pc=0 and enter FETCH; a pending slot is preserved, and capture waits for it to be accepted (REQ-025).
REQ-031 Consumer acceptance with no new capture clears instr_valid next cycle.

Reset
REQ-032 While rst_n=0, asynchronously: state=IDLE, pc=0, instr_valid=0, instr_out=0, instr_pc=0, addr_err=0, busy=0, done=0, imem_read_en=0.
REQ-033 Reset mid-FETCH SHALL discard the slot; no instruction is presented until a new start.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enumeration, ADDR_W=4, INSTR_W=32, and the LAST_ADDR and END_WORD defaults.
REQ-035 The output slot (valid, data and pc register with flush) SHALL be a sub-module, fetch_out_reg; the state machine and pc stay in fetch_sequencer.

Verification
All scenarios use a memory model loaded at 0..7 with 8c0c0000, 8c0d0001, 8c0e0002, 8c0f0003, 01ad4820, 01cf5020, 01494022, ac080004, and with 00000000 at address 8.
REQ-036 start pulse, instr_ready held at 1 -> eight words presented on consecutive cycles with instr_pc 0..7; the word at address 8 is never presented; done=1 after the 8th acceptance.
REQ-037 instr_ready=0 for 3 cycles while instr_pc=2 -> instr_out holds 8c0e0002, imem_read_en=0, pc is unchanged; resumes with 8c0f0003.
REQ-038 redirect_valid with redirect_addr=5 while the slot holds pc 1 -> slot flushed; next presented instruction is 01cf5020 with instr_pc=5.
REQ-039 redirect_addr=15 -> addr_err=1, enter DONE; a later start clears addr_err and refetches 8c0c0000.
REQ-040 Memory filled with non-zero words at 0..14 -> 15 words presented, last instr_pc=14, then done=1 with no wrap to 0.
REQ-041 rst_n low for 1 cycle at instr_pc=3 -> instr_valid=0 immediately, state IDLE; no output until start.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the state enumeration, bus widths and the default memory-map limits.
package fetch_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 32;

  localparam int                 DEF_LAST_ADDR = 14;
  localparam logic [INSTR_W-1:0] DEF_END_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port plus the valid/ready output slot of the sequencer.
// The master side is the sequencer; the slave side is memory plus consumer.
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_read_en;
  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_instruction;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    output imem_read_en,
    output imem_address,
    input  imem_instruction,
    output instr_valid,
    output instr_out,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_read_en,
    input  imem_address,
    output imem_instruction,
    input  instr_valid,
    input  instr_out,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_out_reg.sv
// Output slot: one instruction word with its fetch address and a valid flag.
// Flush beats load, and load beats consumer acceptance.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic               ready,
  output logic               valid,
  output logic [INSTR_W-1:0] data,
  output logic [ADDR_W-1:0]  pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequential instruction fetcher: walks memory from address 0 until the end
// marker or the last address, with redirect support and a one-word output slot.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                 LAST_ADDR = DEF_LAST_ADDR,
  parameter logic [INSTR_W-1:0] END_WORD  = DEF_END_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  fetch_if.master           bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic              can_capture;
  logic              slot_load;
  logic              slot_flush;

  assign can_capture = !bus.instr_valid || bus.instr_ready;

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    err_d            = err_q;
    bus.imem_read_en = 1'b0;
    bus.imem_address = '0;
    slot_load        = 1'b0;
    slot_flush       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        bus.imem_address = pc_q;
        if (redirect_valid) begin
          // A redirect wins over any capture in the same cycle.
          slot_flush = 1'b1;
          if (redirect_addr > LAST) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            pc_d = redirect_addr;
          end
        end else if (can_capture) begin
          bus.imem_read_en = 1'b1;
          if (bus.imem_instruction == END_WORD) begin
            state_d = ST_DONE;
          end else begin
            slot_load = 1'b1;
            if (pc_q == LAST) begin
              state_d = ST_DONE;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          err_d   = 1'b0;
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  fetch_out_reg u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .flush     (slot_flush),
    .load_data (bus.imem_instruction),
    .load_pc   (pc_q),
    .ready     (bus.instr_ready),
    .valid     (bus.instr_valid),
    .data      (bus.instr_out),
    .pc        (bus.instr_pc)
  );

  assign busy     = (state_q == ST_FETCH);
  assign done     = (state_q == ST_DONE) && !bus.instr_valid;
  assign addr_err = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised and directed bench for fetch_sequencer with a behavioural model
// compared against every output on every falling clock edge.
module tb_fetch_sequencer;

  localparam int          LAST    = 14;
  localparam logic [31:0] END_W   = 32'h0000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [3:0] redirect_addr = '0;
  logic       ready = 1'b0;
  logic       busy, done, addr_err;

  logic [31:0] mem [0:15];
  logic [31:0] prog [0:7];

  int checks = 0;
  int errors = 0;

  fetch_if bus ();

  assign bus.imem_instruction = mem[bus.imem_address];
  assign bus.instr_ready      = ready;

  fetch_sequencer #(.LAST_ADDR(LAST), .END_WORD(END_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .busy           (busy),
    .done           (done),
    .addr_err       (addr_err),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "running" means fetching, "finished" means the program ended.
  typedef struct packed {
    logic        run;
    logic        fin;
    logic        v;
    logic        err;
    logic [3:0]  pc;
    logic [3:0]  wpc;
    logic [31:0] word;
  } mstate_t;

  mstate_t m = '0;
  logic [31:0] log_w[$];
  int          log_pc[$];

  function automatic mstate_t model_next(mstate_t s, logic st, logic rv, logic [3:0] ra, logic rdy);
    mstate_t n = s;
    logic [31:0] w;
    if (s.run) begin
      if (rv) begin
        n.v = 1'b0;
        if (int'(ra) > LAST) begin
          n.err = 1'b1; n.run = 1'b0; n.fin = 1'b1;
        end else n.pc = ra;
      end else if (!s.v || rdy) begin
        w = mem[s.pc];
        if (w == END_W) begin
          n.v = 1'b0; n.run = 1'b0; n.fin = 1'b1;
        end else begin
          n.v = 1'b1; n.word = w; n.wpc = s.pc;
          if (int'(s.pc) == LAST) begin
            n.run = 1'b0; n.fin = 1'b1;
          end else n.pc = s.pc + 4'd1;
        end
      end
    end else begin
      if (s.v && rdy) n.v = 1'b0;
      if (st) begin
        n.run = 1'b1; n.fin = 1'b0; n.err = 1'b0; n.pc = 4'd0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
    end else begin
      if (m.v && ready) begin
        log_w.push_back(m.word);
        log_pc.push_back(int'(m.wpc));
      end
      m <= model_next(m, start, redirect_valid, redirect_addr, ready);
    end
  end

  always @(negedge clk) begin
    check("imem_read_en", {31'd0, bus.imem_read_en},
          {31'd0, m.run && (!m.v || ready) && !redirect_valid});
    check("imem_address", {28'd0, bus.imem_address}, m.run ? {28'd0, m.pc} : 32'd0);
    check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m.v});
    check("instr_out", bus.instr_out, m.word);
    check("instr_pc", {28'd0, bus.instr_pc}, {28'd0, m.wpc});
    check("busy", {31'd0, busy}, {31'd0, m.run});
    check("done", {31'd0, done}, {31'd0, m.fin && !m.v});
    check("addr_err", {31'd0, addr_err}, {31'd0, m.err});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_slot(input int pc, input int max_cycles);
    int n = 0;
    while (!(m.v && int'(m.wpc) == pc) && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_slot", {31'd0, m.v && int'(m.wpc) == pc}, 32'd1);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
  endtask

  task automatic check_prog_log(input string tag);
    check({tag, "_count"}, log_w.size(), 32'd8);
    for (int i = 0; i < 8 && i < log_w.size(); i++) begin
      check({tag, "_word"}, log_w[i], prog[i]);
      check({tag, "_pc"}, log_pc[i], i);
    end
  endtask

  initial begin
    prog = '{32'h8c0c0000, 32'h8c0d0001, 32'h8c0e0002, 32'h8c0f0003,
             32'h01ad4820, 32'h01cf5020, 32'h01494022, 32'hac080004};
    load_prog();

    // Reset state.
    tick(2);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read_en", {31'd0, bus.imem_read_en}, 32'd0);
    check("rst_instr_out", bus.instr_out, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Straight run with the consumer always ready.
    ready = 1'b1;
    log_w.delete(); log_pc.delete();
    pulse_start();
    wait_done(40);
    check_prog_log("run");
    tick(2);
    check("run_idle_read", {31'd0, bus.imem_read_en}, 32'd0);

    // Consumer stall while the slot holds address 2.
    log_w.delete(); log_pc.delete();
    pulse_start();
    wait_slot(2, 20);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_word", bus.instr_out, 32'h8c0e0002);
      check("stall_read_en", {31'd0, bus.imem_read_en}, 32'd0);
      check("stall_pc", {28'd0, bus.imem_address}, 32'd3);
      tick();
    end
    ready = 1'b1;
    wait_done(40);
    check_prog_log("stall");

    // Redirect to address 5 while the slot holds address 1.
    pulse_start();
    wait_slot(1, 20);
    ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 4'd5;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush", {31'd0, bus.instr_valid}, 32'd0);
    log_w.delete(); log_pc.delete();
    ready = 1'b1;
    wait_done(40);
    check("redir_count", log_w.size(), 32'd3);
    check("redir_first_word", log_w[0], 32'h01cf5020);
    check("redir_first_pc", log_pc[0], 32'd5);

    // Out-of-range redirect, then restart.
    pulse_start();
    tick(2);
    redirect_valid = 1'b1;
    redirect_addr = 4'd15;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("err_flag", {31'd0, addr_err}, 32'd1);
    check("err_done", {31'd0, done}, 32'd1);
    tick();
    log_w.delete(); log_pc.delete();
    pulse_start();
    @(negedge clk);
    check("err_cleared", {31'd0, addr_err}, 32'd0);
    tick();
    wait_done(40);
    check("err_refetch", log_w[0], 32'h8c0c0000);

    // Full memory with no end marker, random consumer back-pressure.
    for (int i = 0; i < 16; i++) mem[i] = $urandom() | 32'h1;
    log_w.delete(); log_pc.delete();
    pulse_start();
    for (int n = 0; n < 200 && !done; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ready = 1'b1;
    wait_done(10);
    check("full_count", log_w.size(), 32'd15);
    check("full_last_pc", log_pc[log_pc.size()-1], 32'd14);
    tick(3);
    check("full_no_wrap", {31'd0, busy}, 32'd0);

    // Reset in the middle of a fetch.
    load_prog();
    pulse_start();
    wait_slot(3, 20);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(4);
    check("rst_mid_idle", {31'd0, bus.instr_valid}, 32'd0);

    // Random traffic with random memory contents and occasional resets.
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom() | 32'h1);
    for (int n = 0; n < 3000; n++) begin
      start          = ($urandom_range(0, 15) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = 4'($urandom_range(0, 15));
      ready          = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      if (n % 500 == 499)
        for (int i = 0; i < 16; i++)
          mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom() | 32'h1);
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
